sdram_slot_arbiter: RTL
=======================

// Module: sdram_slot_arbiter
// PURPOSE
//  Shares the single SDRAM port between three requesters: CPU/video memory
//  (addrController), HPS download writes (ROM/disk images) and floppy-image byte reads.
//  Grants one requester per SDRAM slot. Each slot is aligned to the `sync` pulse (cep).
//  Drives the sdram controller's din/addr/ds/we/oe. Returns read data with a one-cycle ack.
// PARAMETERS
//  SLOT_LEN  8   clk_sys cycles per SDRAM slot (sync period)
//  RD_LAT    5   cycles after slot start at which sdram_dout is valid
//  MAX_WAIT  3   slots a pending dio/dsk request may lose to CPU before forced grant
//  AW        25  SDRAM word-address width
// PORTS
//  clk_sys     in   1   system clock
//  n_reset     in   1   synchronous, active-low reset
//  sync        in   1   slot-start strobe, one cycle every SLOT_LEN clocks
//  cpu_req     in   1   CPU access request, level, held until cpu_ack
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  word address
//  cpu_din     in   16  write data
//  cpu_ds      in   2   byte strobes {UDS,LDS}, active-high
//  cpu_ack     out  1   one-cycle completion pulse
//  cpu_dout    out  16  read data, valid with cpu_ack, held until next CPU read
//  dio_req     in   1   download word-write request, held until dio_ack
//  dio_addr    in   AW  word address
//  dio_din     in   16  write data (always ds=2'b11)
//  dio_ack     out  1   one-cycle completion pulse
//  dsk_req     in   1   floppy-image byte-read request, held until dsk_ack
//  dsk_addr    in   AW+1 byte address; bit0 selects byte
//  dsk_ack     out  1   one-cycle completion pulse
//  dsk_dout    out  8   byte: addr[0]=0 -> dout[15:8], 1 -> dout[7:0]
//  sdram_addr  out  AW  / sdram_din out 16 / sdram_ds out 2 / sdram_we out 1 / sdram_oe out 1
//  sdram_dout  in   16  controller read data
//  grant       out  2   0 none, 1 cpu, 2 dio, 3 dsk (current slot owner)
//  overrun     out  1   sticky: sync seen before slot data phase reached; cleared by reset
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; wait counters 0; slot_cnt 0.
//  - States: IDLE, ACTIVE.
//  - IDLE + sync + any req: choose an owner, register its addr/din/ds/we onto the sdram_* outputs
//    (oe = ~we), set grant, slot_cnt=0, go ACTIVE. This happens on the same edge as sync.
//  - IDLE + sync + no req: stay IDLE, sdram_we/oe=0.
//  - ACTIVE: slot_cnt increments each clock.
//  - At slot_cnt==RD_LAT-1:
//      - capture sdram_dout into the owner's dout;
//      - pulse the owner's ack for one cycle;
//      - drop sdram_we/oe;
//      - grant=0;
//      - go IDLE.
//  - Latency: ack is RD_LAT clocks after the granting sync edge.
//  - Selection, evaluated at sync:
//      1. A dio or dsk requester whose wait counter == MAX_WAIT wins; dio before dsk if both.
//      2. Otherwise cpu_req wins.
//      3. Otherwise round-robin between dio and dsk, starting with dio after reset.
//  - Wait counters: per dio/dsk. Increment (saturating at MAX_WAIT) on each sync where the
//    requester is pending and not granted. Clear on its grant or when its req is low.
//  - dsk reads: sdram_addr=dsk_addr[AW:1], ds=2'b11, we=0.
//  - dio writes: ds=2'b11, we=1, no data capture.
//  - A request dropped mid-slot: the slot still completes and the ack is still pulsed.
//  - A req still high on the ack cycle counts as a new request at the next sync.
//  - sync while ACTIVE: ignored (no new grant), overrun set.
//  - n_reset low mid-slot: slot aborted, no ack, outputs 0 on the next edge.
//  - Requests and addresses are sampled only at sync. Changes between syncs have no effect.
// STRUCTURE
//  - Package sdram_arb_pkg holds:
//      - typedef grant_t (NONE/CPU/DIO/DSK);
//      - typedef state_t (IDLE/ACTIVE);
//      - default localparams SLOT_LEN/RD_LAT/MAX_WAIT.
//  - Sub-module sdram_wait_counter, instantiated for dio and dsk:
//      - inputs: pending, granted, sync;
//      - output: starved (count==MAX_WAIT).
//  - Top level holds: selection logic, slot counter, output/data registers.
// TESTING
//  1. CPU read alone: cpu_req=1, we=0, addr=25'h000100, sdram_dout=16'hBEEF at slot_cnt 4
//     -> sdram_oe=1 from the sync edge; cpu_ack 5 clocks later; cpu_dout=16'hBEEF.
//  2. dio write: dio_req, addr=25'h080000, din=16'h1234
//     -> sdram_we=1, ds=2'b11, din=16'h1234 for 5 clocks; dio_ack once; no capture.
//  3. Starvation: cpu_req held continuously with dsk_req=1
//     -> CPU granted 3 slots, dsk granted on the 4th; dsk counter then 0.
//  4. dsk byte read: dsk_addr odd, sdram_dout=16'hA55A -> dsk_dout=8'h5A.
//     Same with even address -> 8'hA5.
//  5. dio and dsk pending, no cpu: grants alternate dio, dsk, dio.
//     Inject a sync at slot_cnt 2 -> ignored, overrun=1.
//  6. n_reset low at slot_cnt 2 of a CPU write -> no cpu_ack, we/oe/grant=0 next edge.
//     After release, the first grant follows the next sync.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing for the SDRAM slot arbiter.
package sdram_arb_pkg;
  localparam int SLOT_LEN = 8;
  localparam int RD_LAT   = 5;
  localparam int MAX_WAIT = 3;
  localparam int AW       = 25;

  typedef enum logic [1:0] {NONE = 2'd0, CPU = 2'd1, DIO = 2'd2, DSK = 2'd3} grant_t;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/sdram_wait_counter.sv
// Counts evaluated slots a pending requester has lost; starved once MAX_WAIT is reached.
// Updates only on the evaluation strobe, so it adds no latency to the grant path.
module sdram_wait_counter #(
  parameter int MAX_WAIT = sdram_arb_pkg::MAX_WAIT
) (
  input  logic clk_sys,
  input  logic n_reset,
  input  logic sync,
  input  logic pending,
  input  logic granted,
  output logic starved
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      count <= '0;
    end else if (sync) begin
      if (!pending || granted) count <= '0;
      else if (count != CW'(MAX_WAIT)) count <= count + 1'b1;
    end
  end

  assign starved = (count == CW'(MAX_WAIT));
endmodule

// File: rtl/sdram_slot_arbiter.sv
// Grants one of cpu/dio/dsk per sync-aligned SDRAM slot and drives the controller port.
// Ack is RD_LAT clocks after the granting sync; requesters hold req until ack.
module sdram_slot_arbiter #(
  parameter int SLOT_LEN = sdram_arb_pkg::SLOT_LEN,
  parameter int RD_LAT   = sdram_arb_pkg::RD_LAT,
  parameter int MAX_WAIT = sdram_arb_pkg::MAX_WAIT,
  parameter int AW       = sdram_arb_pkg::AW
) (
  input  logic          clk_sys,
  input  logic          n_reset,
  input  logic          sync,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_ds,
  output logic          cpu_ack,
  output logic [15:0]   cpu_dout,
  input  logic          dio_req,
  input  logic [AW-1:0] dio_addr,
  input  logic [15:0]   dio_din,
  output logic          dio_ack,
  input  logic          dsk_req,
  input  logic [AW:0]   dsk_addr,
  output logic          dsk_ack,
  output logic [7:0]    dsk_dout,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_ds,
  output logic          sdram_we,
  output logic          sdram_oe,
  input  logic [15:0]   sdram_dout,
  output logic [1:0]    grant,
  output logic          overrun
);
  import sdram_arb_pkg::*;

  localparam int CNT_W = $clog2(SLOT_LEN);

  state_t          state, state_nxt;
  grant_t          owner, owner_nxt, sel;
  logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
  logic            rr_dsk, rr_dsk_nxt;   // round-robin: dsk preferred on next tie
  logic            dsk_lo, dsk_lo_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [15:0]     din_nxt, cpu_dout_nxt;
  logic [1:0]      ds_nxt;
  logic            we_nxt, oe_nxt, cpu_ack_nxt, dio_ack_nxt, dsk_ack_nxt, overrun_nxt;
  logic [7:0]      dsk_dout_nxt;
  logic            eval, dio_starved, dsk_starved;

  assign eval = sync && (state == IDLE);

  sdram_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_dio_wait (
    .clk_sys(clk_sys), .n_reset(n_reset), .sync(eval),
    .pending(dio_req), .granted(sel == DIO), .starved(dio_starved)
  );

  sdram_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_dsk_wait (
    .clk_sys(clk_sys), .n_reset(n_reset), .sync(eval),
    .pending(dsk_req), .granted(sel == DSK), .starved(dsk_starved)
  );

  always_comb begin
    sel = NONE;
    if (dio_req && dio_starved)      sel = DIO;
    else if (dsk_req && dsk_starved) sel = DSK;
    else if (cpu_req)                sel = CPU;
    else if (dio_req && dsk_req)     sel = rr_dsk ? DSK : DIO;
    else if (dio_req)                sel = DIO;
    else if (dsk_req)                sel = DSK;
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    slot_cnt_nxt = slot_cnt;
    rr_dsk_nxt   = rr_dsk;
    dsk_lo_nxt   = dsk_lo;
    addr_nxt     = sdram_addr;
    din_nxt      = sdram_din;
    ds_nxt       = sdram_ds;
    we_nxt       = sdram_we;
    oe_nxt       = sdram_oe;
    cpu_dout_nxt = cpu_dout;
    dsk_dout_nxt = dsk_dout;
    cpu_ack_nxt  = 1'b0;
    dio_ack_nxt  = 1'b0;
    dsk_ack_nxt  = 1'b0;
    overrun_nxt  = overrun | (sync && (state == ACTIVE));
    case (state)
      IDLE: begin
        if (sync && (sel != NONE)) begin
          state_nxt    = ACTIVE;
          owner_nxt    = sel;
          slot_cnt_nxt = '0;
          case (sel)
            CPU: begin
              addr_nxt = cpu_addr; din_nxt = cpu_din; ds_nxt = cpu_ds;
              we_nxt   = cpu_we;   oe_nxt  = ~cpu_we;
            end
            DIO: begin
              addr_nxt = dio_addr; din_nxt = dio_din; ds_nxt = 2'b11;
              we_nxt   = 1'b1;     oe_nxt  = 1'b0;    rr_dsk_nxt = 1'b1;
            end
            DSK: begin
              addr_nxt = dsk_addr[AW:1]; din_nxt = '0; ds_nxt = 2'b11;
              we_nxt   = 1'b0; oe_nxt = 1'b1; dsk_lo_nxt = dsk_addr[0]; rr_dsk_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ACTIVE: begin
        slot_cnt_nxt = slot_cnt + 1'b1;
        if (slot_cnt == CNT_W'(RD_LAT - 1)) begin
          state_nxt = IDLE;
          owner_nxt = NONE;
          we_nxt    = 1'b0;
          oe_nxt    = 1'b0;
          case (owner)
            CPU: begin
              cpu_ack_nxt = 1'b1;
              if (!sdram_we) cpu_dout_nxt = sdram_dout;
            end
            DIO: dio_ack_nxt = 1'b1;
            DSK: begin
              dsk_ack_nxt  = 1'b1;
              dsk_dout_nxt = dsk_lo ? sdram_dout[7:0] : sdram_dout[15:8];
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      state <= IDLE;      owner <= NONE;      slot_cnt <= '0;
      rr_dsk <= 1'b0;     dsk_lo <= 1'b0;
      sdram_addr <= '0;   sdram_din <= '0;    sdram_ds <= '0;
      sdram_we <= 1'b0;   sdram_oe <= 1'b0;
      cpu_dout <= '0;     dsk_dout <= '0;
      cpu_ack <= 1'b0;    dio_ack <= 1'b0;    dsk_ack <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt; owner <= owner_nxt; slot_cnt <= slot_cnt_nxt;
      rr_dsk <= rr_dsk_nxt; dsk_lo <= dsk_lo_nxt;
      sdram_addr <= addr_nxt; sdram_din <= din_nxt; sdram_ds <= ds_nxt;
      sdram_we <= we_nxt;   sdram_oe <= oe_nxt;
      cpu_dout <= cpu_dout_nxt; dsk_dout <= dsk_dout_nxt;
      cpu_ack <= cpu_ack_nxt;   dio_ack <= dio_ack_nxt; dsk_ack <= dsk_ack_nxt;
      overrun <= overrun_nxt;
    end
  end

  assign grant = owner;
endmodule
